// File: rtl/dual_port_ram_sync.sv
// Two-port synchronous RAM with registered reads, write-write collision flag and
// an optional post-reset clear sweep that locks out both ports while it runs.
module dual_port_ram_sync #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 6,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] din_0,
    input  logic              we_0,
    input  logic              re_0,
    output logic [DATA_W-1:0] dout_0,
    output logic              dout_valid_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] din_1,
    input  logic              we_1,
    input  logic              re_1,
    output logic [DATA_W-1:0] dout_1,
    output logic              dout_valid_1,
    output logic              collision,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              hit;
    logic              wr_0;
    logic              wr_1;
    logic              rd_0;
    logic              rd_1;
    logic [DATA_W-1:0] rd_data_0;
    logic [DATA_W-1:0] rd_data_1;

    assign run  = (state == ST_RUN);
    assign busy = (state == ST_CLEAR);

    // Requests are single-cycle strobes with no ready: a request is taken at an
    // edge only when rst=0 and busy=0, otherwise it is dropped without trace.
    always_comb begin
        hit  = run && !rst && we_0 && we_1 && (addr_0 == addr_1);
        wr_0 = run && !rst && we_0;
        wr_1 = run && !rst && we_1 && !hit;
        rd_0 = run && !rst && re_0 && !we_0;
        rd_1 = run && !rst && re_1 && !we_1;
    end

    // Cross-port read-during-write: RDW_MODE selects the stored word or the
    // word being written by the other port this edge.
    always_comb begin
        rd_data_0 = mem[addr_0];
        rd_data_1 = mem[addr_1];
        if (RDW_MODE != 0) begin
            if (wr_1 && (addr_1 == addr_0)) rd_data_0 = din_1;
            if (wr_0 && (addr_0 == addr_1)) rd_data_1 = din_0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr     <= '0;
            dout_0       <= '0;
            dout_1       <= '0;
            dout_valid_0 <= 1'b0;
            dout_valid_1 <= 1'b0;
            collision    <= 1'b0;
        end else begin
            collision    <= hit;
            dout_valid_0 <= rd_0;
            dout_valid_1 <= rd_1;
            dout_0       <= rd_0 ? rd_data_0 : '0;
            dout_1       <= rd_1 ? rd_data_1 : '0;
            if (state == ST_CLEAR) begin
                // Counter parks on the last address; the sweep ends instead of wrapping.
                if (clr_addr == LAST_ADDR) state <= ST_RUN;
                else clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_addr] <= '0;
            end else begin
                if (wr_0) mem[addr_0] <= din_0;
                if (wr_1) mem[addr_1] <= din_1;
            end
        end
    end
endmodule

// File: tb/tb_dual_port_ram_sync.sv
// Directed bench for dual_port_ram_sync: old-data and new-data instances share
// one stimulus stream; vectors in a table plus reset/clear sequences.
module tb_dual_port_ram_sync;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] addr_0, addr_1;
    logic [7:0] din_0, din_1;
    logic       we_0, re_0, we_1, re_1;

    logic [7:0] dout_0, dout_1, dout_0n, dout_1n;
    logic       dout_valid_0, dout_valid_1, collision, busy;
    logic       dout_valid_0n, dout_valid_1n, collision_n, busy_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dual_port_ram_sync #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut (
        .clk(clk), .rst(rst),
        .addr_0(addr_0), .din_0(din_0), .we_0(we_0), .re_0(re_0),
        .dout_0(dout_0), .dout_valid_0(dout_valid_0),
        .addr_1(addr_1), .din_1(din_1), .we_1(we_1), .re_1(re_1),
        .dout_1(dout_1), .dout_valid_1(dout_valid_1),
        .collision(collision), .busy(busy)
    );

    dual_port_ram_sync #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut_new (
        .clk(clk), .rst(rst),
        .addr_0(addr_0), .din_0(din_0), .we_0(we_0), .re_0(re_0),
        .dout_0(dout_0n), .dout_valid_0(dout_valid_0n),
        .addr_1(addr_1), .din_1(din_1), .we_1(we_1), .re_1(re_1),
        .dout_1(dout_1n), .dout_valid_1(dout_valid_1n),
        .collision(collision_n), .busy(busy_n)
    );

    typedef struct {
        logic       we0, re0;
        logic [5:0] a0;
        logic [7:0] d0;
        logic       we1, re1;
        logic [5:0] a1;
        logic [7:0] d1;
        logic [7:0] e_d0, e_d0n;
        logic       e_v0;
        logic [7:0] e_d1, e_d1n;
        logic       e_v1;
        logic       e_col;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(
        input logic we0, input logic re0, input logic [5:0] a0, input logic [7:0] d0,
        input logic we1, input logic re1, input logic [5:0] a1, input logic [7:0] d1,
        input logic [7:0] e_d0, input logic [7:0] e_d0n, input logic e_v0,
        input logic [7:0] e_d1, input logic [7:0] e_d1n, input logic e_v1,
        input logic e_col);
        vec_t v;
        v.we0 = we0; v.re0 = re0; v.a0 = a0; v.d0 = d0;
        v.we1 = we1; v.re1 = re1; v.a1 = a1; v.d1 = d1;
        v.e_d0 = e_d0; v.e_d0n = e_d0n; v.e_v0 = e_v0;
        v.e_d1 = e_d1; v.e_d1n = e_d1n; v.e_v1 = e_v1;
        v.e_col = e_col;
        return v;
    endfunction

    task automatic idle_inputs();
        we_0 = 1'b0; re_0 = 1'b0; addr_0 = '0; din_0 = '0;
        we_1 = 1'b0; re_1 = 1'b0; addr_1 = '0; din_1 = '0;
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        check({name, "_busy_new"}, {31'd0, busy_n}, 32'd1);
        check({name, "_outs"}, {dout_0, dout_1, dout_valid_0, dout_valid_1, collision}, 32'd0);
        check({name, "_outs_new"}, {dout_0n, dout_1n, dout_valid_0n, dout_valid_1n, collision_n}, 32'd0);
    endtask

    // Counts busy cycles starting from the sample after the last rst edge and
    // flags any output activity seen while busy.
    task automatic measure_busy(input string name);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (busy && n < 200) begin
            if (collision || dout_valid_0 || dout_valid_1 || collision_n || dout_valid_0n || dout_valid_1n)
                bad++;
            @(posedge clk);
            #1;
            n++;
        end
        idle_inputs();
        check({name, "_busy_len"}, n, 32'd64);
        check({name, "_busy_new"}, {31'd0, busy_n}, 32'd0);
        check({name, "_lockout"}, bad, 32'd0);
    endtask

    task automatic read_zero(input logic [5:0] a);
        addr_0 = a; re_0 = 1'b1; addr_1 = ~a; re_1 = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("clr_rd0_%0d", a), {23'd0, dout_valid_0, dout_0}, 32'h100);
        check($sformatf("clr_rd1_%0d", ~a), {23'd0, dout_valid_1, dout_1}, 32'h100);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 5,  8'hA5, 0, 0, 0,  8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        vecs[1]  = mk(0, 0, 0,  8'h00, 0, 1, 5,  8'h00, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 1, 0);
        vecs[2]  = mk(0, 0, 0,  8'h00, 0, 0, 5,  8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 9,  8'h11, 1, 0, 9,  8'h22, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1);
        vecs[4]  = mk(0, 1, 9,  8'h00, 0, 0, 0,  8'h00, 8'h11, 8'h11, 1, 8'h00, 8'h00, 0, 0);
        vecs[5]  = mk(1, 0, 9,  8'h11, 1, 0, 10, 8'h22, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        vecs[6]  = mk(0, 1, 9,  8'h00, 0, 1, 10, 8'h00, 8'h11, 8'h11, 1, 8'h22, 8'h22, 1, 0);
        vecs[7]  = mk(1, 0, 3,  8'h33, 0, 0, 0,  8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        vecs[8]  = mk(1, 0, 3,  8'h44, 0, 1, 3,  8'h00, 8'h00, 8'h00, 0, 8'h33, 8'h44, 1, 0);
        vecs[9]  = mk(0, 1, 3,  8'h00, 0, 1, 3,  8'h00, 8'h44, 8'h44, 1, 8'h44, 8'h44, 1, 0);
        vecs[10] = mk(0, 1, 20, 8'h00, 1, 1, 20, 8'h5A, 8'h00, 8'h5A, 1, 8'h00, 8'h00, 0, 0);
        vecs[11] = mk(0, 1, 20, 8'h00, 0, 1, 20, 8'h00, 8'h5A, 8'h5A, 1, 8'h5A, 8'h5A, 1, 0);
        vecs[12] = mk(1, 0, 0,  8'h3C, 1, 0, 63, 8'hC3, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
        vecs[13] = mk(0, 1, 63, 8'h00, 0, 1, 0,  8'h00, 8'hC3, 8'hC3, 1, 8'h3C, 8'h3C, 1, 0);
        vecs[14] = mk(1, 0, 40, 8'h01, 1, 0, 40, 8'h02, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1);
        vecs[15] = mk(0, 1, 40, 8'h00, 0, 1, 40, 8'h00, 8'h01, 8'h01, 1, 8'h01, 8'h01, 1, 0);

        // Reset held for several edges, with a write request that must be discarded.
        idle_inputs();
        we_0 = 1'b1; addr_0 = 6; din_0 = 8'h99;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_state($sformatf("rst_hold%0d", i));
        end

        // Clear sweep with colliding writes to address 7 that must be ignored.
        rst = 1'b0;
        we_0 = 1'b1; addr_0 = 7; din_0 = 8'hFF;
        we_1 = 1'b1; addr_1 = 7; din_1 = 8'hEE;
        measure_busy("sweep");

        for (int a = 0; a < 64; a++) read_zero(6'(a));
        idle_inputs();

        for (int i = 0; i < 16; i++) begin
            we_0 = vecs[i].we0; re_0 = vecs[i].re0; addr_0 = vecs[i].a0; din_0 = vecs[i].d0;
            we_1 = vecs[i].we1; re_1 = vecs[i].re1; addr_1 = vecs[i].a1; din_1 = vecs[i].d1;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_p0", i), {23'd0, dout_valid_0, dout_0}, {23'd0, vecs[i].e_v0, vecs[i].e_d0});
            check($sformatf("v%0d_p1", i), {23'd0, dout_valid_1, dout_1}, {23'd0, vecs[i].e_v1, vecs[i].e_d1});
            check($sformatf("v%0d_p0_new", i), {23'd0, dout_valid_0n, dout_0n}, {23'd0, vecs[i].e_v0, vecs[i].e_d0n});
            check($sformatf("v%0d_p1_new", i), {23'd0, dout_valid_1n, dout_1n}, {23'd0, vecs[i].e_v1, vecs[i].e_d1n});
            check($sformatf("v%0d_col", i), {30'd0, collision, collision_n}, {30'd0, vecs[i].e_col, vecs[i].e_col});
            check($sformatf("v%0d_busy", i), {30'd0, busy, busy_n}, 32'd0);
        end
        idle_inputs();

        // Reset 20 cycles into a sweep; a read and write at the reset edge are dropped.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_clear_busy", {31'd0, busy}, 32'd1);
        re_0 = 1'b1; addr_0 = 20;
        we_1 = 1'b1; addr_1 = 6; din_1 = 8'h99;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_rst");
        rst = 1'b0;
        idle_inputs();
        we_0 = 1'b1; re_0 = 1'b1; addr_0 = 5; din_0 = 8'hEE;
        re_1 = 1'b1; addr_1 = 1;
        measure_busy("restart");

        read_zero(6'd5);
        read_zero(6'd9);
        read_zero(6'd20);
        read_zero(6'd63);
        idle_inputs();
        @(posedge clk);
        #1;
        check("final_idle", {dout_valid_0, dout_valid_1, collision, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
